// File: rtl/rand_pkg.sv
// rand_pkg: shared constants, FSM state type and LCG step for the random server.
// Contents: LCG_A/LCG_C multiplier and increment, LCG_W state width, RAND_W result width,
//           rs_state_t FSM encoding, lcg_step() one-step generator update.
package rand_pkg;

  localparam logic [31:0] LCG_A  = 32'h41C64E6D;
  localparam logic [31:0] LCG_C  = 32'h3039;
  localparam int          LCG_W  = 31;
  localparam int          RAND_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } rs_state_t;

  // Only the low 31 bits of the 32-bit product/sum matter for mod 2^31.
  function automatic logic [LCG_W-1:0] lcg_step(input logic [LCG_W-1:0] x);
    return LCG_W'({1'b0, x} * LCG_A + LCG_C);
  endfunction

endpackage

// File: rtl/rand_urem16.sv
// rand_urem16: sequential 16-bit restoring remainder unit, one dividend bit per cycle.
// Ports: clk/rst; start loads dividend/divisor; done is high during the cycle that
//        processes the last bit, and rem carries the final remainder in that same cycle.
module rand_urem16
  import rand_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RAND_W-1:0] dividend,
  input  logic [RAND_W-1:0] divisor,
  output logic              done,
  output logic [RAND_W-1:0] rem
);

  localparam int CNT_W = $clog2(RAND_W);

  logic [RAND_W-1:0] q;
  logic [RAND_W-1:0] d;
  logic [RAND_W-1:0] r;
  logic [RAND_W-1:0] r_nx;
  logic [RAND_W:0]   trial;
  logic [CNT_W-1:0]  cnt;
  logic              active;

  // The partial remainder always stays below the divisor, so 16 bits of state
  // suffice; only the shifted trial value needs the 17th bit.
  always_comb begin
    trial = {r, q[RAND_W-1]};
    if (trial >= {1'b0, d}) r_nx = RAND_W'(trial - {1'b0, d});
    else                    r_nx = trial[RAND_W-1:0];
  end

  // rem is the step result, so the owner can capture it on the same edge
  // that consumes the final bit.
  assign done = active && (cnt == '0);
  assign rem  = r_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= '0;
      d      <= '0;
      r      <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      q      <= dividend;
      d      <= divisor;
      r      <= '0;
      cnt    <= CNT_W'(RAND_W - 1);
      active <= |divisor;
    end else if (active) begin
      r   <= r_nx;
      q   <= {q[RAND_W-2:0], 1'b0};
      cnt <= cnt - 1'b1;
      if (cnt == '0) active <= 1'b0;
    end
  end

endmodule

// File: rtl/rand_server.sv
// rand_server: one 31-bit LCG shared round-robin among N_REQ requesters, result mod bound.
// Ports: req/bound per requester in; seed_we/seed_val reload the LCG; ack one-hot pulse,
//        rdata result (valid with ack), busy while not IDLE. All outputs registered.
module rand_server
  import rand_pkg::*;
#(
  parameter int               N_REQ = 4,
  parameter logic [LCG_W-1:0] SEED  = 31'd1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*RAND_W-1:0] bound,
  input  logic                    seed_we,
  input  logic [LCG_W-1:0]        seed_val,
  output logic [N_REQ-1:0]        ack,
  output logic [RAND_W-1:0]       rdata,
  output logic                    busy
);

  localparam int IW = $clog2(N_REQ);

  // Returns {found, index}: first set bit after from_last, wrapping. Iterating
  // from the farthest offset down lets the nearest hit overwrite the others.
  function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] r,
                                          input logic [IW-1:0]    from_last);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(from_last) + k) % N_REQ;
      if (r[idx]) res = {1'b1, idx[IW-1:0]};
    end
    return res;
  endfunction

  rs_state_t         state, state_nx;
  logic [LCG_W-1:0]  x;
  logic [LCG_W-1:0]  x_adv;
  logic [IW-1:0]     g;
  logic [IW-1:0]     last;
  logic [IW-1:0]     pick_idx;
  logic              pick_vld;
  logic              grant;
  logic [RAND_W-1:0] raw;
  logic [RAND_W-1:0] bound_sel;
  logic              u_done;
  logic [RAND_W-1:0] u_rem;
  logic [N_REQ-1:0]  ack_d;
  logic [RAND_W-1:0] rdata_d;
  logic              busy_d;

  assign {pick_vld, pick_idx} = rr_pick(req, last);
  assign grant     = (state == IDLE) && pick_vld;
  assign x_adv     = lcg_step(x);
  assign raw       = x_adv[LCG_W-1 -: RAND_W];
  assign bound_sel = bound[{pick_idx, 4'b0000} +: RAND_W];

  rand_urem16 u_urem (
    .clk      (clk),
    .rst      (rst),
    .start    (grant && (bound_sel != '0)),
    .dividend (raw),
    .divisor  (bound_sel),
    .done     (u_done),
    .rem      (u_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = (bound_sel != '0) ? DIV : DONE;
      DIV:     if (u_done) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values for the registered outputs. A zero bound completes straight
  // from the grant with the unreduced raw value.
  always_comb begin
    ack_d   = '0;
    rdata_d = rdata;
    busy_d  = (state_nx != IDLE);
    if (grant && (bound_sel == '0)) begin
      ack_d[pick_idx] = 1'b1;
      rdata_d         = raw;
    end
    if ((state == DIV) && u_done) begin
      ack_d[g] = 1'b1;
      rdata_d  = u_rem;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack   <= '0;
      rdata <= '0;
      busy  <= 1'b0;
      x     <= SEED;
      g     <= '0;
      last  <= IW'(N_REQ - 1);
    end else begin
      ack   <= ack_d;
      rdata <= rdata_d;
      busy  <= busy_d;
      // A reload wins over the advance of a same-cycle grant.
      if (seed_we)    x <= seed_val;
      else if (grant) x <= x_adv;
      if (grant)         g    <= pick_idx;
      if (state == DONE) last <= g;
    end
  end

endmodule

// File: tb/tb_rand_server.sv
// tb_rand_server: directed and randomized checks of rand_server against a transaction-level model.
// Ports: none; drives the DUT on the falling edge and compares 2ns after each rising edge.
module tb_rand_server;

  localparam int          N    = 4;
  localparam logic [30:0] SEED = 31'd1;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*16-1:0]   bound;
  logic              seed_we;
  logic [30:0]       seed_val;
  logic [N-1:0]      ack;
  logic [15:0]       rdata;
  logic              busy;

  rand_server #(.N_REQ(N), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .req(req), .bound(bound), .seed_we(seed_we),
    .seed_val(seed_val), .ack(ack), .rdata(rdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int mode   = 0;   // 0 directed, 1 all-requesters order run, 2 random run
  int ack_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model: one server, a countdown per transaction
  logic [30:0]  m_x;
  int           m_last, m_g, m_t, m_lat;
  bit           m_busy;
  logic [15:0]  m_res;
  logic [N-1:0] exp_ack;
  bit           exp_busy;

  function automatic logic [30:0] ref_lcg(input logic [30:0] v);
    longint unsigned p;
    p = (longint'(v) * 64'h41C64E6D + 64'h3039) % 64'h80000000;
    return p[30:0];
  endfunction

  always @(posedge clk) begin
    logic [15:0] rv, bv;
    bit found;
    if (rst) begin
      m_x = SEED; m_last = N - 1; m_busy = 0; m_t = 0; m_lat = 0; m_g = 0;
      exp_ack = '0; exp_busy = 0;
    end else begin
      if (m_busy) begin
        m_t++;
        if (m_t > m_lat) m_busy = 0;
      end else if (|req) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && req[(m_last + k) % N]) begin
            found = 1;
            m_g = (m_last + k) % N;
          end
        end
        m_last = m_g;
        m_x    = ref_lcg(m_x);
        rv     = 16'(m_x >> 15);
        bv     = bound[16*m_g +: 16];
        m_res  = (bv == 0) ? rv : 16'(rv % bv);
        m_lat  = (bv == 0) ? 0 : 16;
        m_t    = 0;
        m_busy = 1;
      end
      if (seed_we) m_x = seed_val;
      exp_busy = m_busy;
      exp_ack  = (m_busy && m_t == m_lat) ? N'(1 << m_g) : '0;
    end
    #2;
    chk("ack", 32'(ack), 32'(exp_ack));
    chk("busy", 32'(busy), 32'(exp_busy));
    if (rst) chk("rdata_in_reset", 32'(rdata), 32'd0);
    else if (exp_ack != 0) chk("rdata", 32'(rdata), 32'(m_res));
    if (!rst && ack != 0)
      for (int i = 0; i < N; i++) if (ack[i]) ack_log.push_back(i);
  end

  // ---------------- free-running requester behaviour for modes 1 and 2
  function automatic logic [15:0] rand_bound();
    case ($urandom_range(0, 5))
      0:       return 16'd0;
      1:       return 16'd1;
      2:       return 16'hFFFF;
      3:       return 16'($urandom_range(2, 20));
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  always @(negedge clk) begin
    if (mode == 1) begin
      for (int i = 0; i < N; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i]) req[i] = 1'b1;
      end
    end else if (mode == 2) begin
      for (int i = 0; i < N; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && !(m_busy && m_g == i) && $urandom_range(0, 63) == 0) req[i] = 1'b0;
        if ($urandom_range(0, 7) == 0) bound[16*i +: 16] = rand_bound();
      end
      seed_we  = ($urandom_range(0, 99) == 0);
      seed_val = 31'($urandom);
    end
  end

  // ---------------- directed helpers
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; seed_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_req(input int idx, input logic [15:0] b, input bit sw,
                        output logic [15:0] got, output int cyc);
    @(negedge clk);
    bound[16*idx +: 16] = b;
    req[idx] = 1'b1;
    seed_we  = sw;
    seed_val = 31'd1;
    cyc = 0;
    got = '0;
    while (cyc < 40) begin
      @(negedge clk);
      seed_we = 1'b0;
      cyc++;
      if (ack[idx]) break;
    end
    req[idx] = 1'b0;
    got = rdata;
  endtask

  initial begin
    logic [15:0] got;
    int          cyc, n;
    int          ord[5] = '{0, 1, 2, 3, 0};

    rst = 1'b1; req = '0; bound = '0; seed_we = 1'b0; seed_val = '0;
    do_reset();
    #1;
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);

    // First value after reset, bound 10: raw 33676 -> 6, ack in cycle 17.
    do_req(0, 16'd10, 1'b0, got, cyc);
    chk("first_b10_cycle", 32'(cyc), 32'd17);
    chk("first_b10_rdata", 32'(got), 32'd6);
    chk("first_dut_x", 32'(dut.x), 32'd1103527590);
    chk("first_model_x", 32'(m_x), 32'd1103527590);

    do_reset();
    do_req(0, 16'd0, 1'b0, got, cyc);
    chk("b0_cycle", 32'(cyc), 32'd1);
    chk("b0_rdata", 32'(got), 32'h838C);

    do_reset();
    do_req(0, 16'd1, 1'b0, got, cyc);
    chk("b1_rdata", 32'(got), 32'd0);

    do_reset();
    do_req(2, 16'hFFFF, 1'b0, got, cyc);
    chk("bffff_rdata", 32'(got), 32'd33676);

    // Reload in the grant cycle: this request still uses the advanced state,
    // the next one replays the post-reset value.
    do_reset();
    do_req(0, 16'd10, 1'b1, got, cyc);
    chk("seed_grant_rdata", 32'(got), 32'd6);
    chk("seed_grant_x", 32'(dut.x), 32'd1);
    do_req(0, 16'd10, 1'b0, got, cyc);
    chk("seed_replay_rdata", 32'(got), 32'd6);

    // Reset in the middle of a division.
    do_reset();
    @(negedge clk);
    bound[15:0] = 16'd10;
    req[0] = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rdata", 32'(rdata), 32'd0);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_req(0, 16'd10, 1'b0, got, cyc);
    chk("midrst_retry_cycle", 32'(cyc), 32'd17);
    chk("midrst_retry_rdata", 32'(got), 32'd6);

    // All four requesting: round-robin order from requester 0.
    do_reset();
    @(negedge clk);
    ack_log.delete();
    for (int i = 0; i < N; i++) bound[16*i +: 16] = 16'(100 + i);
    req = '1;
    mode = 1;
    n = 0;
    while (ack_log.size() < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    mode = 0;
    for (int k = 0; k < 5; k++)
      chk("rr_order", (ack_log.size() > k) ? 32'(ack_log[k]) : 32'hFFFF, 32'(ord[k]));
    req = '0;
    repeat (25) @(negedge clk);

    // Random requests, bounds and reloads until 1000 completions.
    do_reset();
    ack_log.delete();
    mode = 2;
    n = 0;
    while (ack_log.size() < 1000 && n < 50000) begin
      @(negedge clk);
      n++;
    end
    mode = 0;
    seed_we = 1'b0;
    chk("random_completions", 32'(ack_log.size() >= 1000), 32'd1);
    req = '0;
    repeat (25) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
